// File: rtl/mp3_stream_feeder_pkg.sv
// Shared definitions for the MP3 stream feeder: FSM states, track address
// table and default FIFO depth.
package mp3_stream_feeder_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PUSH,
        S_DRAIN
    } feeder_state_e;

    localparam int NUM_TRACKS     = 4;
    localparam int FIFO_DEPTH_DEF = 4;

    // Word-address windows of the three music ROMs (end address inclusive)
    localparam logic [15:0] ROM0_BASE = 16'hFFFE;
    localparam logic [15:0] ROM0_END  = 16'h0001;
    localparam logic [15:0] ROM1_BASE = 16'h0000;
    localparam logic [15:0] ROM1_END  = 16'h0002;
    localparam logic [15:0] ROM2_BASE = 16'hFFFF;
    localparam logic [15:0] ROM2_END  = 16'hFFFF;

    // Index 3 is the last entry of the packed table and aliases ROM0
    localparam logic [NUM_TRACKS-1:0][15:0] TRACK_BASE = {ROM0_BASE, ROM2_BASE, ROM1_BASE, ROM0_BASE};
    localparam logic [NUM_TRACKS-1:0][15:0] TRACK_END  = {ROM0_END,  ROM2_END,  ROM1_END,  ROM0_END};

endpackage

// File: rtl/mp3_stream_feeder_fifo.sv
// Byte FIFO with occupancy count and synchronous flush; head reads as zero
// while empty so byte_data is clean between bursts.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][7:0] mem_q, mem_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full, wr_fire, rd_fire;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;
    assign count   = count_q;
    assign rd_data = empty ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_fire) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({wr_fire, rd_fire})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mp3_stream_feeder.sv
// Streams 16-bit words of the selected track from memory into a byte FIFO
// (high byte first) feeding a valid/ready SPI stage.
module mp3_stream_feeder
    import mp3_stream_feeder_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        sel,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic [7:0]        byte_data,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    feeder_state_e     state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d, end_q, end_d;
    logic [15:0]       word_q, word_d;
    logic              lo_q, lo_d, done_q, done_d;

    logic              fifo_wr, fifo_flush, fifo_empty, pop;
    logic [7:0]        fifo_wdata;
    logic [CW-1:0]     fifo_count;

    assign fifo_flush = stop && (state_q != S_IDLE);
    assign pop        = !fifo_empty && byte_ready;
    assign byte_valid = !fifo_empty;
    assign mem_addr   = cnt_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        end_d      = end_q;
        word_d     = word_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        mem_en     = 1'b0;
        fifo_wr    = 1'b0;
        fifo_wdata = lo_q ? word_q[7:0] : word_q[15:8];
        if (fifo_flush) begin
            state_d = S_IDLE;
            lo_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        cnt_d   = ADDR_W'(TRACK_BASE[sel]);
                        end_d   = ADDR_W'(TRACK_END[sel]);
                        state_d = S_FETCH;
                    end
                end
                // Two free slots before issuing means the word never overflows the FIFO
                S_FETCH: begin
                    if (fifo_count <= CW'(FIFO_DEPTH - 2)) begin
                        mem_en  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    word_d  = mem_data;
                    state_d = S_PUSH;
                end
                S_PUSH: begin
                    fifo_wr = 1'b1;
                    lo_d    = !lo_q;
                    if (lo_q) begin
                        if (cnt_q == end_q) begin
                            state_d = S_DRAIN;
                        end else begin
                            cnt_d   = cnt_q + ADDR_W'(1);
                            state_d = S_FETCH;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && fifo_count == CW'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            end_q   <= '0;
            word_q  <= '0;
            lo_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            end_q   <= end_d;
            word_q  <= word_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (fifo_flush),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (byte_ready),
        .rd_data (byte_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule
